prod_accum: RTL

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/approx_mult_pkg.sv | 25 ++
 rtl/prod_accum_add.sv | 30 +++
 rtl/prod_accum.sv | 139 +++++++++++++
 3 files changed

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding,
// default widths and the input-side ready rule.
package approx_mult_pkg;

   localparam int ACC_W_DEF = 16;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } pa_state_e;

   // A beat can be taken unless a result is held that downstream is not draining.
   function automatic logic pa_in_ready(input pa_state_e st, input logic out_ready);
      logic rdy;
      if (st == ST_HOLD) begin
         rdy = out_ready;
      end else begin
         rdy = 1'b1;
      end
      return rdy;
   endfunction

endpackage

// File: rtl/prod_accum_add.sv
// Accumulator adder for prod_accum. Widens to ACC_W+1 bits so the carry-out
// is visible. Optional macro PROD_ACCUM_SAT_EN: clamp to all-ones on carry
// instead of wrapping modulo 2^ACC_W.
module prod_accum_add #(
   parameter int ACC_W = 16
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [7:0]       prod_i,
   output logic [ACC_W-1:0] acc_o,
   output logic             carry_o
);

   logic [ACC_W:0] sum_s;

   // Widened add; carry selects clamp (saturating build) or is only reported.
   always_comb begin
      sum_s   = {1'b0, acc_i} + {{(ACC_W + 1 - 8){1'b0}}, prod_i};
      carry_o = sum_s[ACC_W];
`ifdef PROD_ACCUM_SAT_EN
      if (sum_s[ACC_W]) begin
         acc_o = {ACC_W{1'b1}};
      end else begin
         acc_o = sum_s[ACC_W-1:0];
      end
`else
      acc_o = sum_s[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/prod_accum.sv
// Product accumulator: sums a vector of 8-bit product beats delimited by
// in_last, then holds {sum, beat count, overflow} until downstream takes it.
// A new vector may start on the same cycle the held result drains.
// Optional macro PROD_ACCUM_SAT_EN (see prod_accum_add): saturating sum.
module prod_accum
   import approx_mult_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_prod,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_ovf
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   pa_state_e        state_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q;
   logic [ACC_W-1:0] out_sum_q;
   logic [CNT_W-1:0] out_cnt_q;
   logic             out_ovf_q;

   logic             in_ready_s;
   logic             beat_acc_s;
   logic             capture_s;
   logic [ACC_W-1:0] add_acc_s;
   logic             add_carry_s;

   prod_accum_add #(.ACC_W(ACC_W)) u_add (
      .acc_i   (acc_q),
      .prod_i  (in_prod),
      .acc_o   (add_acc_s),
      .carry_o (add_carry_s)
   );

   // Handshake qualifiers: beat accepted, and whether it closes the vector.
   always_comb begin
      in_ready_s = pa_in_ready(state_q, out_ready);
      beat_acc_s = in_valid && in_ready_s;
      capture_s  = beat_acc_s && in_last;
   end

   // Next accumulator/count/overflow: first beat loads, later beats add.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (beat_acc_s) begin
         if (state_q == ST_ACCUM) begin
            acc_d = add_acc_s;
            ovf_d = ovf_q | add_carry_s;
            if (cnt_q == CNT_MAX) begin
               cnt_d = cnt_q;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end else begin
            acc_d = {{(ACC_W - 8){1'b0}}, in_prod};
            cnt_d = CNT_ONE;
            ovf_d = 1'b0;
         end
      end else begin
         acc_d = acc_q;
         cnt_d = cnt_q;
         ovf_d = ovf_q;
      end
   end

   // FSM, datapath and result registers; reset drops any partial vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= {ACC_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= {ACC_W{1'b0}};
         out_cnt_q   <= {CNT_W{1'b0}};
         out_ovf_q   <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;

         case (state_q)
            ST_IDLE, ST_ACCUM: begin
               if (beat_acc_s) begin
                  state_q <= in_last ? ST_HOLD : ST_ACCUM;
               end else begin
                  state_q <= state_q;
               end
            end
            ST_HOLD: begin
               if (beat_acc_s) begin
                  state_q <= in_last ? ST_HOLD : ST_ACCUM;
               end else if (out_ready) begin
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_HOLD;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase

         if (capture_s) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= acc_d;
            out_cnt_q   <= cnt_d;
            out_ovf_q   <= ovf_d;
         end else if ((state_q == ST_HOLD) && out_ready) begin
            out_valid_q <= 1'b0;
         end else begin
            out_valid_q <= out_valid_q;
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cnt   = out_cnt_q;
   assign out_ovf   = out_ovf_q;

endmodule
